// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC, IR and MAR and runs a ready-handshaked
// read port for instruction and operand fetches under a small internal FSM.
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter int                OPC_W    = 3,
   parameter logic [OPC_W-1:0]  HALT_OPC = {OPC_W{1'b1}},
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ready,
   output logic [OPC_W-1:0]          opcode,
   output logic [DATA_W-OPC_W-1:0]   operand,
   output logic                      instr_valid,
   input  logic                      opnd_req,
   output logic [DATA_W-1:0]         opnd_data,
   output logic                      opnd_valid,
   input  logic                      exec_done,
   input  logic                      branch_taken,
   input  logic [ADDR_W-1:0]         branch_target,
   output logic [ADDR_W-1:0]         pc,
   output logic                      halted
);

   localparam int OPND_W = DATA_W - OPC_W;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, OPND, HALT} state_t;

   state_t              state, state_nx;
   logic [DATA_W-1:0]   ir, ir_nx;
   logic [ADDR_W-1:0]   pc_nx, addr_nx, opnd_addr;
   logic [DATA_W-1:0]   od_nx;
   logic                rd_nx, ov_nx;

   assign opcode      = ir[DATA_W-1 -: OPC_W];
   assign operand     = ir[OPND_W-1:0];
   assign instr_valid = (state == EXEC);
   assign halted      = (state == HALT);

   // Operand field is used directly as an address: zero-extend or keep low bits.
   generate
      if (OPND_W >= ADDR_W) begin : g_trunc
         assign opnd_addr = operand[ADDR_W-1:0];
      end else begin : g_zext
         assign opnd_addr = {{(ADDR_W-OPND_W){1'b0}}, operand};
      end
   endgenerate

   always_comb begin
      state_nx = state;
      ir_nx    = ir;
      pc_nx    = pc;
      addr_nx  = mem_addr;
      rd_nx    = mem_rd;
      od_nx    = opnd_data;
      ov_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               addr_nx  = pc;
               rd_nx    = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            if (mem_ready) begin
               ir_nx    = mem_rdata;
               rd_nx    = 1'b0;
               state_nx = (mem_rdata[DATA_W-1 -: OPC_W] == HALT_OPC) ? HALT : EXEC;
            end
         end
         EXEC: begin
            // Retirement beats an operand request raised in the same cycle.
            if (exec_done) begin
               pc_nx    = branch_taken ? branch_target : pc + 1'b1;
               state_nx = IDLE;
            end else if (opnd_req) begin
               addr_nx  = opnd_addr;
               rd_nx    = 1'b1;
               state_nx = OPND;
            end
         end
         OPND: begin
            if (mem_ready) begin
               od_nx    = mem_rdata;
               ov_nx    = 1'b1;
               rd_nx    = 1'b0;
               state_nx = EXEC;
            end
         end
         HALT: begin
            rd_nx = 1'b0;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         ir         <= '0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         opnd_data  <= '0;
         opnd_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         ir         <= ir_nx;
         mem_addr   <= addr_nx;
         mem_rd     <= rd_nx;
         opnd_data  <= od_nx;
         opnd_valid <= ov_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for halt and
// reset-during-read, then random traffic against a transaction-level model.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b0, run = 1'b0, mem_ready = 1'b0;
   logic       opnd_req = 1'b0, exec_done = 1'b0, branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic [7:0] junk = 8'h00;
   logic [7:0] mem [256];
   logic [7:0] mem_addr, mem_rdata, opnd_data, pc;
   logic       mem_rd, instr_valid, opnd_valid, halted;
   logic [2:0] opcode;
   logic [4:0] operand;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Memory answers from its array only when ready; otherwise junk is on the bus.
   assign mem_rdata = mem_ready ? mem[mem_addr] : junk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
      .opnd_req(opnd_req), .opnd_data(opnd_data), .opnd_valid(opnd_valid),
      .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .halted(halted)
   );

   typedef struct {
      logic       rst, run, rdy, ed, orq, bt;
      logic [7:0] tgt;
      logic       rd;
      logic [7:0] addr, pc;
      logic [2:0] opc;
      logic [4:0] opnd;
      logic       iv, ov;
      logic [7:0] od;
      logic       h;
   } vec_t;

   function automatic vec_t v(input logic rst, run, rdy, ed, orq, bt, input logic [7:0] tgt,
                              input logic rd, input logic [7:0] addr, pcv,
                              input logic [2:0] opc, input logic [4:0] opnd,
                              input logic iv, ov, input logic [7:0] od, input logic h);
      vec_t r;
      r.rst = rst; r.run = run; r.rdy = rdy; r.ed = ed; r.orq = orq; r.bt = bt; r.tgt = tgt;
      r.rd = rd; r.addr = addr; r.pc = pcv; r.opc = opc; r.opnd = opnd;
      r.iv = iv; r.ov = ov; r.od = od; r.h = h;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rd, input logic [7:0] addr, pcv,
                             input logic [2:0] opc, input logic [4:0] opnd,
                             input logic iv, ov, input logic [7:0] od, input logic h);
      chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, ".pc"}, 32'(pc), 32'(pcv));
      chk({tag, ".opcode"}, 32'(opcode), 32'(opc));
      chk({tag, ".operand"}, 32'(operand), 32'(opnd));
      chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
      chk({tag, ".opnd_valid"}, 32'(opnd_valid), 32'(ov));
      chk({tag, ".opnd_data"}, 32'(opnd_data), 32'(od));
      chk({tag, ".halted"}, 32'(halted), 32'(h));
   endtask

   task automatic apply_row(input vec_t r, input string tag);
      reset = r.rst; run = r.run; mem_ready = r.rdy; exec_done = r.ed;
      opnd_req = r.orq; branch_taken = r.bt; branch_target = r.tgt;
      @(posedge clk);
      #1;
      check_outs(tag, r.rd, r.addr, r.pc, r.opc, r.opnd, r.iv, r.ov, r.od, r.h);
   endtask

   // Reference model: which read is outstanding, whether an instruction is
   // being executed, and the architectural values the spec says to expose.
   logic [7:0] m_pc, m_ir, m_addr, m_od;
   logic       m_ov, m_halt, m_exec;
   int         m_busy;   // 0 none, 1 instruction read, 2 operand read

   task automatic model_step();
      if (reset) begin
         m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00; m_od = 8'h00;
         m_ov = 1'b0; m_halt = 1'b0; m_exec = 1'b0; m_busy = 0;
      end else begin
         m_ov = 1'b0;
         if (!m_halt) begin
            if (m_busy == 1) begin
               if (mem_ready) begin
                  m_ir = mem[m_addr];
                  m_busy = 0;
                  if (m_ir[7:5] == 3'b111) m_halt = 1'b1;
                  else m_exec = 1'b1;
               end
            end else if (m_busy == 2) begin
               if (mem_ready) begin
                  m_od = mem[m_addr];
                  m_ov = 1'b1;
                  m_busy = 0;
               end
            end else if (m_exec) begin
               if (exec_done) begin
                  m_pc = branch_taken ? branch_target : m_pc + 8'd1;
                  m_exec = 1'b0;
               end else if (opnd_req) begin
                  m_addr = {3'b000, m_ir[4:0]};
                  m_busy = 2;
               end
            end else if (run) begin
               m_addr = m_pc;
               m_busy = 1;
            end
         end
      end
   endtask

   vec_t tbl [24];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h25; mem[8'h01] = 8'h4A; mem[8'h0A] = 8'h77;
      mem[8'hF0] = 8'h61; mem[8'hFF] = 8'h22; mem[8'h30] = 8'hE0; mem[8'h05] = 8'h33;
      junk = 8'hE0;   // a halt opcode on the bus while not ready must be ignored

      //            rst run rdy ed orq bt tgt     rd addr   pc     opc  opnd   iv ov od     h
      tbl[0]  = v(1, 1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0);
      tbl[1]  = v(0, 1, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0);
      tbl[2]  = v(0, 1, 1, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 3'd1, 5'h05, 1, 0, 8'h00, 0);
      tbl[3]  = v(0, 0, 1, 1, 0, 0, 8'h00,  0, 8'h00, 8'h01, 3'd1, 5'h05, 0, 0, 8'h00, 0);
      tbl[4]  = v(0, 1, 0, 0, 0, 0, 8'h00,  1, 8'h01, 8'h01, 3'd1, 5'h05, 0, 0, 8'h00, 0);
      tbl[5]  = v(0, 0, 0, 0, 0, 0, 8'h00,  1, 8'h01, 8'h01, 3'd1, 5'h05, 0, 0, 8'h00, 0);
      tbl[6]  = v(0, 0, 0, 0, 0, 0, 8'h00,  1, 8'h01, 8'h01, 3'd1, 5'h05, 0, 0, 8'h00, 0);
      tbl[7]  = v(0, 0, 0, 0, 0, 0, 8'h00,  1, 8'h01, 8'h01, 3'd1, 5'h05, 0, 0, 8'h00, 0);
      tbl[8]  = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'h01, 8'h01, 3'd2, 5'h0A, 1, 0, 8'h00, 0);
      tbl[9]  = v(0, 0, 1, 0, 1, 0, 8'h00,  1, 8'h0A, 8'h01, 3'd2, 5'h0A, 0, 0, 8'h00, 0);
      tbl[10] = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'h0A, 8'h01, 3'd2, 5'h0A, 1, 1, 8'h77, 0);
      tbl[11] = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'h0A, 8'h01, 3'd2, 5'h0A, 1, 0, 8'h77, 0);
      tbl[12] = v(0, 0, 1, 1, 1, 1, 8'hF0,  0, 8'h0A, 8'hF0, 3'd2, 5'h0A, 0, 0, 8'h77, 0);
      tbl[13] = v(0, 1, 1, 0, 0, 0, 8'h00,  1, 8'hF0, 8'hF0, 3'd2, 5'h0A, 0, 0, 8'h77, 0);
      tbl[14] = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'hF0, 8'hF0, 3'd3, 5'h01, 1, 0, 8'h77, 0);
      tbl[15] = v(0, 0, 1, 1, 0, 1, 8'hFF,  0, 8'hF0, 8'hFF, 3'd3, 5'h01, 0, 0, 8'h77, 0);
      tbl[16] = v(0, 1, 1, 0, 0, 0, 8'h00,  1, 8'hFF, 8'hFF, 3'd3, 5'h01, 0, 0, 8'h77, 0);
      tbl[17] = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'hFF, 8'hFF, 3'd1, 5'h02, 1, 0, 8'h77, 0);
      tbl[18] = v(0, 0, 1, 1, 0, 0, 8'h00,  0, 8'hFF, 8'h00, 3'd1, 5'h02, 0, 0, 8'h77, 0);
      tbl[19] = v(0, 1, 1, 0, 0, 0, 8'h00,  1, 8'h00, 8'h00, 3'd1, 5'h02, 0, 0, 8'h77, 0);
      tbl[20] = v(0, 0, 1, 0, 0, 0, 8'h00,  0, 8'h00, 8'h00, 3'd1, 5'h05, 1, 0, 8'h77, 0);
      tbl[21] = v(0, 0, 1, 1, 0, 1, 8'h30,  0, 8'h00, 8'h30, 3'd1, 5'h05, 0, 0, 8'h77, 0);
      tbl[22] = v(0, 1, 1, 0, 0, 0, 8'h00,  1, 8'h30, 8'h30, 3'd1, 5'h05, 0, 0, 8'h77, 0);
      tbl[23] = v(0, 1, 1, 0, 0, 0, 8'h00,  0, 8'h30, 8'h30, 3'd7, 5'h00, 0, 0, 8'h77, 1);

      for (int i = 0; i < 24; i++) apply_row(tbl[i], $sformatf("vec%0d", i));

      // HALT holds against run, exec_done and opnd_req
      for (int i = 0; i < 10; i++)
         apply_row(v(0, 1, 1, 1, 1, 1, 8'h55, 0, 8'h30, 8'h30, 3'd7, 5'h00, 0, 0, 8'h77, 1),
                   $sformatf("halt%0d", i));

      // reset recovery, then reset while an operand read is outstanding
      apply_row(v(1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0), "rr0");
      apply_row(v(0, 1, 1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0), "rr1");
      apply_row(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 3'd1, 5'h05, 1, 0, 8'h00, 0), "rr2");
      apply_row(v(0, 0, 1, 0, 1, 0, 8'h00, 1, 8'h05, 8'h00, 3'd1, 5'h05, 0, 0, 8'h00, 0), "rr3");
      apply_row(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h05, 8'h00, 3'd1, 5'h05, 1, 1, 8'h33, 0), "rr4");
      apply_row(v(0, 0, 0, 0, 1, 0, 8'h00, 1, 8'h05, 8'h00, 3'd1, 5'h05, 0, 0, 8'h33, 0), "rr5");
      apply_row(v(0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h05, 8'h00, 3'd1, 5'h05, 0, 0, 8'h33, 0), "rr6");
      apply_row(v(1, 1, 1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0), "rr7");
      apply_row(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0), "rr8");
      apply_row(v(0, 1, 1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 3'd0, 5'h00, 0, 0, 8'h00, 0), "rr9");

      // random traffic against the model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      m_halt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         reset         = (c == 0) ? 1'b1 : (m_halt ? ($urandom % 3 == 0) : ($urandom % 64 == 0));
         run           = ($urandom % 4 != 0);
         mem_ready     = ($urandom % 3 != 0);
         exec_done     = ($urandom % 4 == 0);
         opnd_req      = ($urandom % 3 == 0);
         branch_taken  = ($urandom % 2 == 0);
         branch_target = 8'($urandom);
         junk          = 8'($urandom);
         @(posedge clk);
         model_step();
         #1;
         check_outs($sformatf("rnd%0d", c), m_busy != 0, m_addr, m_pc, m_ir[7:5], m_ir[4:0],
                    m_exec && (m_busy == 0), m_ov, m_od, m_halt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
